// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives a synchronous-read instruction memory and
// buffers returned words with their PC+1 in a small FIFO for decode.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter int          ADDR_WIDTH = 8,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  IM_En,
   output logic [ADDR_WIDTH-1:0] IM_Addr,
   input  logic [31:0]           IM_RD,
   input  logic                  Stall_D,
   input  logic                  Redirect,
   input  logic [31:0]           Redirect_PC,
   output logic [31:0]           Instr_F,
   output logic [31:0]           PC_Plus_One_F,
   output logic                  Valid_F
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   tag_q;
   logic          inflight_q;
   logic [PW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   instr_q [FIFO_DEPTH];
   logic [31:0]   pcp1_q  [FIFO_DEPTH];

   logic          pop, push;
   logic [CW:0]   occ;

   assign Valid_F = (count_q != '0);
   assign pop     = Valid_F & ~Stall_D & ~Redirect;
   assign push    = inflight_q & ~Redirect;

   // Occupancy after this cycle's pop; reserving a slot for every
   // in-flight request guarantees a response always has room.
   assign occ = {1'b0, count_q}
              + {{CW{1'b0}}, inflight_q}
              - {{CW{1'b0}}, pop};

   assign IM_En   = ~rst & ~Redirect & (occ < DEPTH_C);
   assign IM_Addr = pc_q[ADDR_WIDTH-1:0];

   assign Instr_F       = Valid_F ? instr_q[rd_q] : '0;
   assign PC_Plus_One_F = Valid_F ? pcp1_q[rd_q]  : '0;

   always_comb begin
      pc_d    = pc_q + 32'd1;
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         tag_q      <= '0;
         inflight_q <= 1'b0;
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
      end else if (Redirect) begin
         pc_q       <= Redirect_PC;
         inflight_q <= 1'b0;
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
      end else begin
         if (IM_En) begin
            pc_q  <= pc_d;
            tag_q <= pc_d;
         end
         inflight_q <= IM_En;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         instr_q[wr_q] <= IM_RD;
         pcp1_q[wr_q]  <= tag_q;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: IM[a] = a + 100, checks
// latency, stall hold, redirect, reset priority and PC wrap.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        IM_En;
   logic [7:0]  IM_Addr;
   logic [31:0] IM_RD;
   logic        Stall_D;
   logic        Redirect;
   logic [31:0] Redirect_PC;
   logic [31:0] Instr_F;
   logic [31:0] PC_Plus_One_F;
   logic        Valid_F;

   int n_run  = 0;
   int n_fail = 0;

   instruction_fetch_unit #(
      .RESET_PC   (32'h0),
      .ADDR_WIDTH (8),
      .FIFO_DEPTH (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .IM_En         (IM_En),
      .IM_Addr       (IM_Addr),
      .IM_RD         (IM_RD),
      .Stall_D       (Stall_D),
      .Redirect      (Redirect),
      .Redirect_PC   (Redirect_PC),
      .Instr_F       (Instr_F),
      .PC_Plus_One_F (PC_Plus_One_F),
      .Valid_F       (Valid_F)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory
   always @(posedge clk)
      if (IM_En) IM_RD <= {24'h0, IM_Addr} + 32'd100;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic out(input string tag, input logic v,
                      input logic [31:0] ins, input logic [31:0] p1);
      #1;
      chk({tag, ".v"}, {31'h0, Valid_F}, {31'h0, v});
      chk({tag, ".i"}, Instr_F, ins);
      chk({tag, ".p"}, PC_Plus_One_F, p1);
   endtask

   // A response must never arrive with the buffer already full
   always @(negedge clk)
      if (!rst && dut.inflight_q && !Redirect)
         chk("nofull", {30'h0, dut.count_q}, {30'h0, dut.count_q} & 32'h1);

   initial begin
      rst = 1'b1;
      Stall_D = 1'b0;
      Redirect = 1'b0;
      Redirect_PC = '0;
      IM_RD = '0;
      tick();
      tick();
      #1;
      chk("rst.en", {31'h0, IM_En}, 32'h0);
      out("rst", 1'b0, 32'h0, 32'h0);

      // 1: straight-line fetch, 2-cycle latency
      tick(); rst = 1'b0;
      #1;
      chk("c0.en", {31'h0, IM_En}, 32'h1);
      chk("c0.a", {24'h0, IM_Addr}, 32'h0);
      out("c0", 1'b0, 32'h0, 32'h0);
      tick(); out("c1", 1'b0, 32'h0, 32'h0);
      tick(); out("c2", 1'b1, 32'd100, 32'd1);

      // 2: stall four cycles on the second entry
      tick(); Stall_D = 1'b1;
      out("s0", 1'b1, 32'd101, 32'd2);
      chk("s0.en", {31'h0, IM_En}, 32'h0);
      for (int i = 1; i < 4; i++) begin
         tick();
         out("sh", 1'b1, 32'd101, 32'd2);
         chk("sh.en", {31'h0, IM_En}, 32'h0);
      end
      tick(); Stall_D = 1'b0;
      out("s4", 1'b1, 32'd101, 32'd2);
      chk("s4.a", {24'h0, IM_Addr}, 32'd3);
      for (int i = 0; i < 4; i++) begin
         tick();
         out("run", 1'b1, 32'd102 + i, 32'd3 + i);
      end

      // 3: redirect with a response in flight
      tick(); Redirect = 1'b1; Redirect_PC = 32'h40;
      #1;
      chk("r.en", {31'h0, IM_En}, 32'h0);
      tick(); Redirect = 1'b0;
      #1;
      chk("r1.a", {24'h0, IM_Addr}, 32'h40);
      chk("r1.en", {31'h0, IM_En}, 32'h1);
      out("r1", 1'b0, 32'h0, 32'h0);
      tick(); out("r2", 1'b0, 32'h0, 32'h0);
      tick(); out("r3", 1'b1, 32'd164, 32'h41);
      tick(); out("r4", 1'b1, 32'd165, 32'h42);

      // 4: fill the buffer, then redirect while stalled
      tick(); Stall_D = 1'b1;
      tick();
      tick();
      #1;
      chk("f.en", {31'h0, IM_En}, 32'h0);
      out("f", 1'b1, 32'd166, 32'h43);
      tick(); Redirect = 1'b1; Redirect_PC = 32'h10;
      tick(); Redirect = 1'b0; Stall_D = 1'b0;
      out("rs1", 1'b0, 32'h0, 32'h0);
      tick(); out("rs2", 1'b0, 32'h0, 32'h0);
      tick(); out("rs3", 1'b1, 32'd116, 32'h11);
      tick(); out("rs4", 1'b1, 32'd117, 32'h12);

      // 5: reset beats a simultaneous redirect
      tick(); rst = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h80;
      #1;
      chk("x.en", {31'h0, IM_En}, 32'h0);
      tick(); rst = 1'b0; Redirect = 1'b0;
      #1;
      chk("x1.a", {24'h0, IM_Addr}, 32'h0);
      chk("x1.en", {31'h0, IM_En}, 32'h1);
      out("x1", 1'b0, 32'h0, 32'h0);
      tick(); out("x2", 1'b0, 32'h0, 32'h0);
      tick(); out("x3", 1'b1, 32'd100, 32'd1);

      // 6: PC wrap through FFFF_FFFF
      tick(); Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFF;
      tick(); Redirect = 1'b0;
      #1;
      chk("w1.a", {24'h0, IM_Addr}, 32'hFF);
      tick();
      #1;
      chk("w2.a", {24'h0, IM_Addr}, 32'h0);
      tick(); out("w3", 1'b1, 32'd355, 32'h0);
      tick(); out("w4", 1'b1, 32'd100, 32'd1);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
